fetch_stage: RTL and testbench

//  Instruction-fetch stage, upstream of the byte-addressed instruction memory.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the returned word into IF/ID,
// honours decode stalls and execute redirects, and halts once the PC leaves
// the populated code region.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 68
`ifdef FETCH_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W     = 16
`endif
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   input  logic [31:0]       inst_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       inst_o,
   output logic [31:0]       pc_id_o,
   output logic [31:0]       pc_plus8_o,
   output logic              valid_o,
   output logic              halted_o,
   output logic              misalign_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  fetch_count_o,
   output logic [CNT_W-1:0]  stall_count_o
`endif
);

   // Highest address whose word is still fetched; anything above halts fetch.
   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;

   // Next-state and IF/ID capture decisions in redirect > stall > halt > fetch order.
   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      pc_id_d    = pc_id_q;
      valid_d    = valid_q;
      misalign_d = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect_i) begin
               pc_d       = redirect_pc_i & ~32'd3;
               valid_d    = 1'b0;
               misalign_d = |redirect_pc_i[1:0];
            end else if (stall_i) begin
               // Everything holds via the defaults.
            end else if (pc_q > LAST_PC) begin
               valid_d = 1'b0;
               state_d = HALT;
            end else begin
               inst_d  = inst_i;
               pc_id_d = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
            end
         end
         HALT: begin
            if (redirect_i) begin
               pc_d       = redirect_pc_i & ~32'd3;
               valid_d    = 1'b0;
               misalign_d = |redirect_pc_i[1:0];
               state_d    = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State, PC and IF/ID registers; reset discards IF/ID contents at once.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         inst_q     <= 32'd0;
         pc_id_q    <= 32'd0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         pc_id_q    <= pc_id_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o       = pc_q;
   assign inst_o     = inst_q;
   assign pc_id_o    = pc_id_q;
   assign pc_plus8_o = pc_id_q + 32'd8;
   assign valid_o    = valid_q;
   assign halted_o   = (state_q == HALT);
   assign misalign_o = misalign_q;

`ifdef FETCH_PERF_CNT_EN
   logic             fetch_inc, stall_inc;
   logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q;

   assign fetch_inc = (state_q == RUN) && !redirect_i && !stall_i && (pc_q <= LAST_PC);
   assign stall_inc = (state_q == RUN) && !redirect_i && stall_i;

   // Saturating performance counters.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
         if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign fetch_count_o = fetch_cnt_q;
   assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// reset/counter sequence, then randomized stall/redirect traffic against a
// behavioural model. Counter checks are built when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned MEM_WORDS = 17;   // 68 bytes of code

   logic        clk = 1'b0;
   logic        reset_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] inst_i;
   logic [31:0] pc_o, inst_o, pc_id_o, pc_plus8_o;
   logic        valid_o, halted_o, misalign_o;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count_o, stall_count_o;
`endif

   logic [31:0] mem [MEM_WORDS];

   int n_vec  = 0;
   int n_fail = 0;

   fetch_stage dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_i        (inst_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .pc_id_o       (pc_id_o),
      .pc_plus8_o    (pc_plus8_o),
      .valid_o       (valid_o),
      .halted_o      (halted_o),
      .misalign_o    (misalign_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count_o (fetch_count_o),
      .stall_count_o (stall_count_o)
`endif
   );

   always #5 clk = ~clk;

   // Combinational code memory; addresses beyond the code region return junk.
   assign inst_i = (pc_o <= 32'd64) ? mem[pc_o[6:2]] : 32'hDEAD_BEEF;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr <= 32'd64) ? mem[addr[6:2]] : 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
   task automatic apply(input logic st, input logic rd, input logic [31:0] rpc);
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'd0;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_pc, m_pc_id, m_inst;
   bit          m_valid, m_booting, m_halted, m_mis;
   int          m_fc, m_sc;

   task automatic model_reset();
      m_pc = RESET_PC; m_pc_id = 0; m_inst = 0;
      m_valid = 0; m_booting = 1; m_halted = 0; m_mis = 0;
      m_fc = 0; m_sc = 0;
   endtask

   task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc);
      m_mis = 0;
      if (m_booting) begin
         m_booting = 0;
      end else if (rd) begin
         m_pc     = {rpc[31:2], 2'b00};
         m_valid  = 0;
         m_mis    = (rpc % 4) != 0;
         m_halted = 0;
      end else if (m_halted) begin
      end else if (st) begin
         if (m_sc < 65535) m_sc++;
      end else if (m_pc > 32'(MEM_WORDS * 4 - 4)) begin
         m_valid  = 0;
         m_halted = 1;
      end else begin
         m_inst  = mem_word(m_pc);
         m_pc_id = m_pc;
         m_valid = 1;
         m_pc    = m_pc + 32'd4;
         if (m_fc < 65535) m_fc++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          stall;
      bit          redir;
      logic [31:0] rpc;
      logic [31:0] e_pc;
      logic [31:0] e_pc_id;
      bit          e_valid;
      bit          e_halted;
      bit          e_mis;
   } vec_t;

   vec_t tbl [21];

   initial begin
      reset_i = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'd0;
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom();

      //        stall rd  rpc         pc          pc_id       v  h  mis
      tbl[0]  = '{0, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0};  // BOOT
      tbl[1]  = '{0, 0, 32'h00, 32'h04, 32'h00, 1, 0, 0};
      tbl[2]  = '{0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0};
      tbl[3]  = '{0, 0, 32'h00, 32'h0C, 32'h08, 1, 0, 0};
      tbl[4]  = '{0, 0, 32'h00, 32'h10, 32'h0C, 1, 0, 0};
      tbl[5]  = '{1, 0, 32'h00, 32'h10, 32'h0C, 1, 0, 0};  // stall x3
      tbl[6]  = '{1, 0, 32'h00, 32'h10, 32'h0C, 1, 0, 0};
      tbl[7]  = '{1, 0, 32'h00, 32'h10, 32'h0C, 1, 0, 0};
      tbl[8]  = '{0, 0, 32'h00, 32'h14, 32'h10, 1, 0, 0};  // resume
      tbl[9]  = '{1, 1, 32'h04, 32'h04, 32'h10, 0, 0, 0};  // redirect beats stall
      tbl[10] = '{0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0};
      tbl[11] = '{0, 1, 32'h1A, 32'h18, 32'h04, 0, 0, 1};  // misaligned
      tbl[12] = '{0, 0, 32'h00, 32'h1C, 32'h18, 1, 0, 0};
      tbl[13] = '{0, 1, 32'h3C, 32'h3C, 32'h18, 0, 0, 0};
      tbl[14] = '{0, 0, 32'h00, 32'h40, 32'h3C, 1, 0, 0};
      tbl[15] = '{0, 0, 32'h00, 32'h44, 32'h40, 1, 0, 0};  // last legal word
      tbl[16] = '{0, 0, 32'h00, 32'h44, 32'h40, 0, 1, 0};  // halt
      tbl[17] = '{0, 0, 32'h00, 32'h44, 32'h40, 0, 1, 0};
      tbl[18] = '{1, 0, 32'h00, 32'h44, 32'h40, 0, 1, 0};
      tbl[19] = '{0, 1, 32'h00, 32'h00, 32'h40, 0, 0, 0};  // leave HALT
      tbl[20] = '{0, 0, 32'h00, 32'h04, 32'h00, 1, 0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst pc_o", pc_o, RESET_PC);
      check("rst inst_o", inst_o, 32'd0);
      check("rst pc_id_o", pc_id_o, 32'd0);
      check("rst valid_o", 32'(valid_o), 32'd0);
      check("rst halted_o", 32'(halted_o), 32'd0);
      check("rst misalign_o", 32'(misalign_o), 32'd0);
      reset_i = 1'b0;

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
         check($sformatf("v%0d pc_o", i), pc_o, tbl[i].e_pc);
         check($sformatf("v%0d pc_id_o", i), pc_id_o, tbl[i].e_pc_id);
         check($sformatf("v%0d pc_plus8_o", i), pc_plus8_o, tbl[i].e_pc_id + 32'd8);
         check($sformatf("v%0d valid_o", i), 32'(valid_o), 32'(tbl[i].e_valid));
         check($sformatf("v%0d halted_o", i), 32'(halted_o), 32'(tbl[i].e_halted));
         check($sformatf("v%0d misalign_o", i), 32'(misalign_o), 32'(tbl[i].e_mis));
         if (tbl[i].e_valid)
            check($sformatf("v%0d inst_o", i), inst_o, mem_word(tbl[i].e_pc_id));
      end

      // Five fetches, two stalls, then reset asserted between clock edges.
      do_reset();
      apply(0, 0, 0);                        // BOOT
      repeat (5) apply(0, 0, 0);
      repeat (2) apply(1, 0, 0);
      check("seq pc_id_o", pc_id_o, 32'h10);
      check("seq valid_o", 32'(valid_o), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      check("seq fetch_count_o", 32'(fetch_count_o), 32'd5);
      check("seq stall_count_o", 32'(stall_count_o), 32'd2);
`endif
      #2 reset_i = 1'b1;
      #1;
      check("async valid_o", 32'(valid_o), 32'd0);
      check("async pc_id_o", pc_id_o, 32'd0);
      check("async inst_o", inst_o, 32'd0);
      check("async pc_o", pc_o, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
      check("async fetch_count_o", 32'(fetch_count_o), 32'd0);
      check("async stall_count_o", 32'(stall_count_o), 32'd0);
`endif

      // Randomized traffic against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         bit          st, rd;
         logic [31:0] rpc;
         check($sformatf("r%0d pc_o", c), pc_o, m_pc);
         check($sformatf("r%0d pc_id_o", c), pc_id_o, m_pc_id);
         check($sformatf("r%0d inst_o", c), inst_o, m_inst);
         check($sformatf("r%0d pc_plus8_o", c), pc_plus8_o, m_pc_id + 32'd8);
         check($sformatf("r%0d valid_o", c), 32'(valid_o), 32'(m_valid));
         check($sformatf("r%0d halted_o", c), 32'(halted_o), 32'(m_halted));
         check($sformatf("r%0d misalign_o", c), 32'(misalign_o), 32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
         check($sformatf("r%0d fetch_count_o", c), 32'(fetch_count_o), 32'(m_fc));
         check($sformatf("r%0d stall_count_o", c), 32'(stall_count_o), 32'(m_sc));
`endif
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         rpc = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 75)) : $urandom();
         model_edge(st, rd, rpc);
         apply(st, rd, rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
